// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-port controller: zero-clear then round-robin writeback arbitration
// Optional: define RF_WB_ZERO_GUARD_EN to keep r0 hardwired to zero outside INIT.
module rf_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      soft_clear,
  input  logic                      rf_stall,
  output logic                      rf_write_en,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic                      init_done
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0]  clr_cnt;
  logic [PTR_W-1:0]   rr_ptr;
  logic               out_valid;
  logic [ADDR_W-1:0]  out_addr;
  logic [DATA_W-1:0]  out_data;
  logic               clr_pend;

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               found;
  int unsigned        idx;
  logic               can_accept;
  logic               accept;
  logic               retire;
  logic               load_ok;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic [PTR_W-1:0]   next_ptr;

  // Round-robin search starting at rr_ptr, wrapping at NUM_REQ
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
      end
    end
  end

  assign can_accept = ~out_valid | ~rf_stall;
  assign accept     = |req_ready;
  assign retire     = (state == S_RUN) & out_valid & ~rf_stall;
  assign sel_addr   = req_addr[grant_idx*ADDR_W +: ADDR_W];
  assign sel_data   = req_data[grant_idx*DATA_W +: DATA_W];
  assign next_ptr   = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

`ifdef RF_WB_ZERO_GUARD_EN
  assign load_ok = (sel_addr != '0);
`else
  assign load_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_INIT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (!rf_stall && clr_cnt == LAST_ADDR) state_nxt = S_RUN;
      S_RUN:   if (clr_pend && !out_valid)           state_nxt = S_INIT;
      default: state_nxt = S_INIT;
    endcase
  end

  // Write enable is gated by reset_n so the port is quiet while reset is held
  always_comb begin
    req_ready   = '0;
    rf_write_en = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    init_done   = 1'b0;
    case (state)
      S_INIT: begin
        rf_write_en = reset_n & ~rf_stall;
        rf_waddr    = clr_cnt;
      end
      S_RUN: begin
        init_done   = 1'b1;
        req_ready   = grant & {NUM_REQ{can_accept & ~clr_pend}};
        rf_write_en = out_valid & ~rf_stall;
        rf_waddr    = out_addr;
        rf_wdata    = out_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_cnt   <= '0;
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      clr_pend  <= 1'b0;
    end else if (state == S_INIT) begin
      if (!rf_stall) clr_cnt <= clr_cnt + 1'b1;
    end else begin
      if (retire) out_valid <= 1'b0;
      if (accept) begin
        out_valid <= load_ok;
        out_addr  <= sel_addr;
        out_data  <= sel_data;
        rr_ptr    <= next_ptr;
      end
      if (soft_clear) clr_pend <= 1'b1;
      if (clr_pend && !out_valid) clr_pend <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 64;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      soft_clear;
  logic                      rf_stall;
  logic                      rf_write_en;
  logic [ADDR_W-1:0]         rf_waddr;
  logic [DATA_W-1:0]         rf_wdata;
  logic                      init_done;

  logic [ADDR_W+DATA_W-1:0]  exp_q[$];
  logic [DATA_W-1:0]         model[DEPTH];
  int checks = 0;
  int errors = 0;

  rf_wb_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .soft_clear(soft_clear),
    .rf_stall(rf_stall), .rf_write_en(rf_write_en), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: every write on the port must match the head of the expected queue
  always @(negedge clk) begin
    if (rf_write_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write", rf_waddr, rf_wdata);
      end else begin
        check("write", {26'd0, rf_waddr, rf_wdata}, {26'd0, exp_q.pop_front()});
      end
      model[rf_waddr] = rf_wdata;
    end
  end

  task automatic push_init();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({ADDR_W'(i), {DATA_W{1'b0}}});
  endtask

  task automatic wait_init(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (init_done) break;
    end
    check(name, init_done, 1);
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  logic [DATA_W-1:0] tdata [3];
  logic [NUM_REQ-1:0] onehot;
  int zero_ok;

  initial begin
    tdata[0] = 32'h0000_000A; tdata[1] = 32'h0000_000B; tdata[2] = 32'h0000_000C;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'hFFFF_FFFF;
    reset_n = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    soft_clear = 1'b0; rf_stall = 1'b0;

    // Reset values
    #3;
    check("reset_we", rf_write_en, 0);
    check("reset_init_done", init_done, 0);
    check("reset_ready", req_ready, 0);
    check("reset_waddr_wdata", {rf_waddr, rf_wdata}, 0);

    // 1: INIT zero sweep, one stalled cycle in the middle
    repeat (3) @(posedge clk);
    push_init();
    #1 reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 rf_stall = 1'b1;
    @(negedge clk);
    check("init_stall_we", rf_write_en, 0);
    @(posedge clk);
    #1 rf_stall = 1'b0;
    wait_init("init_done_t1");
    check("init_writes_all", exp_q.size(), 0);
    zero_ok = 1;
    for (int i = 0; i < DEPTH; i++) if (model[i] !== 0) zero_ok = 0;
    check("model_all_zero", zero_ok, 1);

    // 2: all requesters valid -> grants 0,1,2,0,1,2
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) set_req(i, ADDR_W'(5 + i), tdata[i]);
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      onehot = 3'b001 << (k % 3);
      check("rr_ready", req_ready, onehot);
      exp_q.push_back({ADDR_W'(5 + k % 3), tdata[k % 3]});
      @(posedge clk);
      #1;
    end
    req_valid = '0;

    // 3: req0 accepted, then 4 stalled cycles with req1 waiting
    set_req(0, 6'd10, 32'h0000_0033);
    req_valid = 3'b001;
    @(negedge clk);
    check("t3_ready0", req_ready, 3'b001);
    exp_q.push_back({6'd10, 32'h0000_0033});
    @(posedge clk);
    #1;
    set_req(1, 6'd11, 32'h0000_0044);
    req_valid = 3'b010;
    rf_stall  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stall_we", rf_write_en, 0);
      check("stall_ready", req_ready, 0);
      check("stall_addr_data", {rf_waddr, rf_wdata}, {6'd10, 32'h0000_0033});
      @(posedge clk);
    end
    #1 rf_stall = 1'b0;
    @(negedge clk);
    check("unstall_we", rf_write_en, 1);
    check("unstall_ready1", req_ready, 3'b010);
    exp_q.push_back({6'd11, 32'h0000_0044});
    @(posedge clk);
    #1 req_valid = '0;

    // 4: r9 write accepted in the same cycle as soft_clear, then full re-clear
    set_req(2, 6'd9, 32'hDEAD_BEEF);
    req_valid  = 3'b100;
    soft_clear = 1'b1;
    @(negedge clk);
    check("t4_ready2", req_ready, 3'b100);
    exp_q.push_back({6'd9, 32'hDEAD_BEEF});
    @(posedge clk);
    #1;
    req_valid  = '0;
    soft_clear = 1'b0;
    push_init();
    @(negedge clk);
    check("clr_pend_ready", req_ready, 0);
    check("clr_done_c1", init_done, 1);
    @(negedge clk);
    check("clr_done_c2", init_done, 1);
    @(negedge clk);
    check("clr_done_drop", init_done, 0);
    wait_init("init_done_t4");
    check("clear_writes_all", exp_q.size(), 0);
    check("r9_cleared", model[9], 0);

    // 6: write to address 0 from req1
    @(posedge clk);
    #1;
    set_req(1, 6'd0, 32'h0000_1234);
    req_valid = 3'b010;
    @(negedge clk);
    check("addr0_ready", req_ready, 3'b010);
`ifndef RF_WB_ZERO_GUARD_EN
    exp_q.push_back({6'd0, 32'h0000_1234});
`endif
    @(posedge clk);
    #1 req_valid = '0;
    repeat (2) @(negedge clk);
    check("addr0_done", exp_q.size(), 0);

    // 5: reset asserted mid-INIT at clr_cnt=20
    @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    push_init();
    #1 reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("midreset_we", rf_write_en, 0);
    check("midreset_out", {init_done, req_ready, rf_waddr, rf_wdata}, 0);
    check("midreset_progress", exp_q.size(), DEPTH - 20);
    exp_q.delete();
    repeat (2) @(posedge clk);
    push_init();
    #1 reset_n = 1'b1;
    wait_init("init_done_t5");
    check("restart_writes_all", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
